riscv_csr_file: RTL and testbench

- Zicsr register file for the Riscv151 core.
- Executes CSRRW/CSRRS/CSRRC and their immediate forms from the execute stage.
- Holds the tohost register (0x51E), which the ISA bench and host tooling poll for pass/fail.
- Also holds the 64-bit cycle and instret counters. This block is the writing end of the tohost handshake.

---
 rtl/riscv_csr_file.sv | 116 +++++++++++
 tb/tb_riscv_csr_file.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_csr_file.sv
// Zicsr register file: tohost mailbox plus 64-bit cycle/instret counters.
// Reads are combinational (pre-edge value); writes commit at the next posedge.
module riscv_csr_file #(
    parameter logic [31:0] RESET_TOHOST  = 32'h0000_0000,
    parameter int unsigned COUNTER_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic        stall,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_src_zero,
    input  logic        instr_retired,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] tohost,
    output logic        tohost_wr
);

    localparam int unsigned CW = COUNTER_WIDTH;

    localparam logic [11:0] ADDR_TOHOST   = 12'h51E;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    logic [CW-1:0] cycle_q;
    logic [CW-1:0] instret_q;
    logic [CW-1:0] cycle_d;
    logic [CW-1:0] instret_d;
    logic [63:0]   cycle_x;
    logic [63:0]   instret_x;
    logic          legal;
    logic          read_only;
    logic          write_req;
    logic          we;
    logic [31:0]   new_val;

    assign cycle_x   = 64'(cycle_q);
    assign instret_x = 64'(instret_q);

    // Address decode and read mux; upper halves zero-extend narrow counters.
    always_comb begin
        csr_rdata = 32'h0;
        legal     = 1'b1;
        case (csr_addr)
            ADDR_TOHOST:                   csr_rdata = tohost;
            ADDR_CYCLE,    ADDR_MCYCLE:    csr_rdata = cycle_x[31:0];
            ADDR_CYCLEH,   ADDR_MCYCLEH:   csr_rdata = cycle_x[63:32];
            ADDR_INSTRET,  ADDR_MINSTRET:  csr_rdata = instret_x[31:0];
            ADDR_INSTRETH, ADDR_MINSTRETH: csr_rdata = instret_x[63:32];
            default:                       legal     = 1'b0;
        endcase
    end

    // RW always writes; RS/RC write only with a non-zero source.
    assign write_req   = (csr_op == OP_RW) || ((csr_op != OP_NONE) && !csr_src_zero);
    assign read_only   = (csr_addr[11:8] == 4'hC);
    assign csr_illegal = csr_en && (!legal || (read_only && write_req));
    assign we          = csr_en && !stall && !rst && write_req && legal && !read_only;

    always_comb begin
        new_val = csr_rdata;
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = csr_rdata | csr_wdata;
            OP_RC:   new_val = csr_rdata & ~csr_wdata;
            default: new_val = csr_rdata;
        endcase
    end

    // A half-write replaces that half and suppresses the increment for the cycle.
    always_comb begin
        cycle_d   = cycle_q + CW'(1);
        instret_d = (instr_retired && !stall) ? instret_q + CW'(1) : instret_q;
        if (we && csr_addr == ADDR_MCYCLE) begin
            cycle_d = {cycle_q[CW-1:32], new_val};
        end else if (we && csr_addr == ADDR_MCYCLEH) begin
            cycle_d = {new_val[CW-33:0], cycle_q[31:0]};
        end
        if (we && csr_addr == ADDR_MINSTRET) begin
            instret_d = {instret_q[CW-1:32], new_val};
        end else if (we && csr_addr == ADDR_MINSTRETH) begin
            instret_d = {new_val[CW-33:0], instret_q[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost    <= RESET_TOHOST;
            tohost_wr <= 1'b0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            tohost_wr <= we && (csr_addr == ADDR_TOHOST);
            if (we && csr_addr == ADDR_TOHOST) begin
                tohost <= new_val;
            end
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_riscv_csr_file.sv
// Directed + randomized bench for riscv_csr_file against an abstract CSR model.
module tb_riscv_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_en;
    logic        stall;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_src_zero;
    logic        instr_retired;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        tohost_wr;

    riscv_csr_file dut (
        .clk          (clk),
        .rst          (rst),
        .csr_en       (csr_en),
        .stall        (stall),
        .csr_op       (csr_op),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_src_zero (csr_src_zero),
        .instr_retired(instr_retired),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .tohost       (tohost),
        .tohost_wr    (tohost_wr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain integers, counters wrap as 64-bit unsigned.
    logic [31:0]     m_tohost;
    longint unsigned m_cycle;
    longint unsigned m_instret;
    bit              m_tw;
    logic [31:0]     last_rdata;
    logic            last_illegal;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_known(input logic [11:0] a);
        case (a)
            12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
            12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h51E:          return m_tohost;
            12'hC00, 12'hB00: return 32'(m_cycle);
            12'hC80, 12'hB80: return 32'(m_cycle >> 32);
            12'hC02, 12'hB02: return 32'(m_instret);
            12'hC82, 12'hB82: return 32'(m_instret >> 32);
            default:          return 32'h0;
        endcase
    endfunction

    // One clock: drive, check combinational outputs, advance model, check state.
    task automatic cyc(input bit r, input bit en, input bit st, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] wd, input bit sz, input bit ret);
        logic [31:0] old, nv;
        bit writes, exp_ill, we, cnt_written, ins_written;
        rst = r; csr_en = en; stall = st; csr_op = op; csr_addr = a;
        csr_wdata = wd; csr_src_zero = sz; instr_retired = ret;
        #3;
        old     = m_read(a);
        writes  = (op == 2'b01) || (op != 2'b00 && !sz);
        exp_ill = en && (!m_known(a) || (a[11:8] == 4'hC && writes));
        we      = !r && en && !st && writes && m_known(a) && a[11:8] != 4'hC;
        case (op)
            2'b01:   nv = wd;
            2'b10:   nv = old | wd;
            2'b11:   nv = old & ~wd;
            default: nv = old;
        endcase
        last_rdata   = csr_rdata;
        last_illegal = csr_illegal;
        if (en) check("rdata", 64'(csr_rdata), 64'(old));
        check("illegal", 64'(csr_illegal), 64'(exp_ill));
        @(posedge clk);
        #1;
        if (r) begin
            m_tohost = 32'h0; m_cycle = 0; m_instret = 0; m_tw = 1'b0;
        end else begin
            m_tw = we && a == 12'h51E;
            if (m_tw) m_tohost = nv;
            cnt_written = we && (a == 12'hB00 || a == 12'hB80);
            ins_written = we && (a == 12'hB02 || a == 12'hB82);
            if (we && a == 12'hB00) m_cycle = (m_cycle & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
            if (we && a == 12'hB80) m_cycle = (m_cycle & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
            if (!cnt_written) m_cycle = m_cycle + 1;
            if (we && a == 12'hB02) m_instret = (m_instret & 64'hFFFF_FFFF_0000_0000) | 64'(nv);
            if (we && a == 12'hB82) m_instret = (m_instret & 64'h0000_0000_FFFF_FFFF) | (64'(nv) << 32);
            if (!ins_written && ret && !st) m_instret = m_instret + 1;
        end
        check("tohost", 64'(tohost), 64'(m_tohost));
        check("tohost_wr", 64'(tohost_wr), 64'(m_tw));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'b00, 12'h000, 32'h0, 0, 0);
    endtask

    logic [11:0] addr_tab [12] = '{12'h51E, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hB00,
                                   12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h300, 12'hC01};
    logic [31:0] ins_before;

    initial begin
        m_tohost = 32'h0; m_cycle = 0; m_instret = 0; m_tw = 1'b0;

        // Reset held 30 cycles; tohost/tohost_wr checked each cycle by the model.
        for (int i = 0; i < 30; i++) cyc(1, 0, 0, 2'b00, 12'h000, 32'h0, 0, 0);
        cyc(0, 1, 0, 2'b00, 12'hC00, 32'h0, 0, 0);
        check("cycle_first", 64'(last_rdata), 64'd0);
        idle(9);
        cyc(0, 1, 0, 2'b00, 12'hC00, 32'h0, 0, 0);
        check("cycle_plus10", 64'(last_rdata), 64'd10);

        // tohost pass
        cyc(0, 1, 0, 2'b01, 12'h51E, 32'h1, 0, 0);
        check("pass_old", 64'(last_rdata), 64'd0);
        check("pass_tohost", 64'(tohost), 64'd1);
        check("pass_wr", 64'(tohost_wr), 64'd1);
        idle(1);
        check("pass_wr_drop", 64'(tohost_wr), 64'd0);

        // tohost fail + clear + suppressed set
        cyc(0, 1, 0, 2'b01, 12'h51E, 32'h0000_000B, 0, 0);
        check("fail_tohost", 64'(tohost), 64'd11);
        cyc(0, 1, 0, 2'b11, 12'h51E, 32'h1, 0, 0);
        check("clear_tohost", 64'(tohost), 64'd10);
        cyc(0, 1, 0, 2'b10, 12'h51E, 32'h0, 1, 0);
        check("rs_zero_tohost", 64'(tohost), 64'd10);
        check("rs_zero_wr", 64'(tohost_wr), 64'd0);

        // Stall gating
        cyc(0, 1, 0, 2'b00, 12'hC02, 32'h0, 0, 0);
        ins_before = last_rdata;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 2'b01, 12'h51E, 32'h55, 0, 1);
            check("stall_tohost", 64'(tohost), 64'd10);
        end
        cyc(0, 1, 0, 2'b00, 12'hC02, 32'h0, 0, 0);
        check("stall_instret", 64'(last_rdata), 64'(ins_before));
        cyc(0, 1, 0, 2'b01, 12'h51E, 32'h55, 0, 0);
        check("unstall_tohost", 64'(tohost), 64'h55);

        // Read-only and unimplemented
        cyc(0, 1, 0, 2'b01, 12'hC00, 32'h1234, 0, 0);
        check("ro_illegal", 64'(last_illegal), 64'd1);
        cyc(0, 1, 0, 2'b00, 12'h7C0, 32'h0, 0, 0);
        check("unimpl_illegal", 64'(last_illegal), 64'd1);
        check("unimpl_rdata", 64'(last_rdata), 64'd0);

        // Counter wrap through mcycle/mcycleh
        cyc(0, 1, 0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 1, 0, 2'b01, 12'hB80, 32'h0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 2'b00, 12'hC80, 32'h0, 0, 0);
        check("wrap_hi", 64'(last_rdata), 64'd1);
        cyc(0, 1, 0, 2'b00, 12'hC00, 32'h0, 0, 0);
        check("wrap_lo", 64'(last_rdata), 64'd2);

        // Reset mid-write
        cyc(1, 1, 0, 2'b01, 12'h51E, 32'h3, 0, 0);
        check("rst_write_tohost", 64'(tohost), 64'd0);
        check("rst_write_wr", 64'(tohost_wr), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                2'($urandom), addr_tab[$urandom_range(0, 11)],
                ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom),
                ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
